// File: rtl/ram_sync_fill.sv
// ram_sync_fill: single-port synchronous RAM with registered reads and a
// built-in fill engine that sweeps a constant or address-XOR pattern over
// every word. The fill owns the array while busy; user accesses are dropped.
module ram_sync_fill #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic [ADDR_W-1:0] adrs,
  input  logic [DATA_W-1:0] din,
  input  logic              _ce,
  input  logic              _we,
  input  logic              _oe,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  input  logic              fill_start,
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_pattern,
  output logic              busy,
  output logic              fill_done,
  output logic              acc_drop
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fa;
  logic [DATA_W-1:0] pattern_q;
  logic              mode_q;
  logic [DATA_W-1:0] fill_data;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic acc, in_rng, acc_ok, fa_last, fill_go;

  assign acc       = ~_ce;
  assign in_rng    = 32'(adrs) < 32'(DEPTH);
  // fill_start steals the cycle even while busy, so a user access in that
  // cycle is dropped regardless of whether the start itself is honoured.
  assign acc_ok    = acc & ~busy & ~fill_start & in_rng;
  assign fill_go   = fill_start & (state == IDLE);
  assign fa_last   = (fa == ADDR_W'(DEPTH-1));
  assign fill_data = mode_q ? (pattern_q ^ DATA_W'(fa)) : pattern_q;

  assign busy      = (state != IDLE);
  assign fill_done = (state == DONE);
  assign dout      = _oe ? '0 : rd_q;

  // FSM state register
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: one DONE cycle after the last fill write
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fill_start) state_nxt = FILL;
      FILL:    if (fa_last)    state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Fill context: pattern/mode captured only on an honoured start, so a
  // start pulse mid-fill cannot disturb the running sweep.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      fa        <= '0;
      pattern_q <= '0;
      mode_q    <= 1'b0;
    end else if (fill_go) begin
      fa        <= '0;
      pattern_q <= fill_pattern;
      mode_q    <= fill_mode;
    end else if (state == FILL) begin
      fa        <= fa_last ? '0 : fa + ADDR_W'(1);
    end
  end

  // Array write port: fill has priority (acc_ok is already low while busy)
  always_ff @(posedge clk) begin
    if (state == FILL)        mem[fa]   <= fill_data;
    else if (acc_ok && !_we)  mem[adrs] <= din;
  end

  // Registered read data plus status pulses
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      rd_q     <= '0;
      rd_valid <= 1'b0;
      acc_drop <= 1'b0;
    end else begin
      rd_valid <= acc_ok & _we;
      acc_drop <= acc & ~acc_ok;
      if (acc_ok && _we) rd_q <= mem[adrs];
    end
  end

endmodule

// File: tb/tb_ram_sync_fill.sv
// Scoreboard bench for ram_sync_fill: a shadow array predicts read data,
// expected words are queued at the read request and popped on rd_valid.
module tb_ram_sync_fill;
  localparam int AW = 7;
  localparam int DW = 16;
  localparam int DP = 128;

  logic          clk = 1'b0;
  logic          _rst = 1'b0;
  logic [AW-1:0] adrs = '0;
  logic [DW-1:0] din = '0;
  logic          _ce = 1'b1, _we = 1'b1, _oe = 1'b0;
  logic [DW-1:0] dout;
  logic          rd_valid;
  logic          fill_start = 1'b0, fill_mode = 1'b0;
  logic [DW-1:0] fill_pattern = '0;
  logic          busy, fill_done, acc_drop;

  ram_sync_fill #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), ._rst(_rst), .adrs(adrs), .din(din), ._ce(_ce), ._we(_we),
    ._oe(_oe), .dout(dout), .rd_valid(rd_valid), .fill_start(fill_start),
    .fill_mode(fill_mode), .fill_pattern(fill_pattern), .busy(busy),
    .fill_done(fill_done), .acc_drop(acc_drop)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] mdl [DP];
  logic [DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Read-data monitor: every rd_valid pulse retires one scoreboard entry
  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) chk("rd_spur", 32'd1, 32'd0);
      else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        chk("rd_data", 32'(dout), _oe ? 32'd0 : 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    _ce = 1'b0; _we = 1'b0; adrs = AW'(a); din = d;
    if (!busy) mdl[a] = d;
    tick();
    _ce = 1'b1; _we = 1'b1;
  endtask

  task automatic do_read(input int a);
    _ce = 1'b0; _we = 1'b1; adrs = AW'(a);
    sb.push_back(mdl[a]);
    tick();
    _ce = 1'b1;
  endtask

  task automatic drain();
    tick(); tick();
  endtask

  // inj: 0 none, 1 user write to addr 3 mid-fill, 2 restart with new pattern
  task automatic run_fill(input logic [DW-1:0] pat, input logic md, input int inj);
    int cyc;
    fill_pattern = pat; fill_mode = md; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    cyc = 1;
    chk("busy_rise", 32'(busy), 32'd1);
    while (!fill_done && cyc < 400) begin
      if (cyc == 20 && inj == 1) begin _ce = 1'b0; _we = 1'b0; adrs = 7'd3; din = 16'h1234; end
      if (cyc == 20 && inj == 2) begin fill_start = 1'b1; fill_pattern = ~pat; fill_mode = ~md; end
      tick();
      cyc++;
      if (cyc == 21 && inj == 1) begin chk("acc_drop_fill", 32'(acc_drop), 32'd1); _ce = 1'b1; _we = 1'b1; end
      if (cyc == 21 && inj == 2) fill_start = 1'b0;
    end
    chk("fill_cycles", 32'(cyc), 32'(DP + 1));
    chk("busy_done", 32'(busy), 32'd1);
    tick();
    chk("done_pulse", 32'(fill_done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    for (int a = 0; a < DP; a++) mdl[a] = md ? (pat ^ DW'(a)) : pat;
  endtask

  initial begin
    for (int a = 0; a < DP; a++) mdl[a] = 'x;
    #12;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(fill_done), 32'd0);
    chk("rst_drop", 32'(acc_drop), 32'd0);
    _rst = 1'b1;
    tick();

    // 1: clear fill, read everything back
    run_fill(16'h0000, 1'b0, 0);
    for (int a = 0; a < DP; a++) do_read(a);
    drain();

    // 2: write/read with output enable on and off
    do_write(7, 16'hA5A5);
    _oe = 1'b1; do_read(7); drain();
    _oe = 1'b0; #1;
    chk("oe_comb", 32'(dout), 32'h0000A5A5);
    do_read(7); drain();

    // _ce high: write attempt must not land
    _ce = 1'b1; _we = 1'b0; adrs = 7'd7; din = 16'hDEAD; tick(); _we = 1'b1;
    chk("ce_hi_drop", 32'(acc_drop), 32'd0);
    do_read(7); drain();

    // same-cycle fill_start drops the user access
    _ce = 1'b0; _we = 1'b1; adrs = 7'd7;
    fill_pattern = 16'hFF00; fill_mode = 1'b1; fill_start = 1'b1;
    tick();
    fill_start = 1'b0; _ce = 1'b1;
    chk("drop_start", 32'(acc_drop), 32'd1);
    chk("no_rd_start", 32'(rd_valid), 32'd0);
    while (busy) tick();
    for (int a = 0; a < DP; a++) mdl[a] = 16'hFF00 ^ DW'(a);

    // 3: XOR-mode fill
    run_fill(16'hFF00, 1'b1, 0);
    do_read(5); do_read(127); drain();

    // 4: user write during fill is dropped
    run_fill(16'h3C3C, 1'b0, 1);
    do_read(3); drain();

    // 6: restart mid-fill ignored
    run_fill(16'h5AA5, 1'b1, 2);
    do_read(0); do_read(64); do_read(127); drain();

    // 5: reset at fill cycle 10
    run_fill(16'h1111, 1'b0, 0);
    fill_pattern = 16'hBEEF; fill_mode = 1'b0; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    _rst = 1'b0; #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(fill_done), 32'd0);
    tick();
    _rst = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); chk("rst_no_done", 32'(fill_done | busy), 32'd0); end
    for (int a = 0; a < 10; a++) mdl[a] = 16'hBEEF;
    for (int a = 0; a < DP; a++) do_read(a);
    drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end
endmodule
